// File: rtl/sparse_pkg.sv
// Shared constants and types for the 2:4 sparse weight path; the activation-side
// selection mux imports this package so both sides agree on the sel layout.
package sparse_pkg;

    localparam int GROUP_LANES   = 8;
    localparam int HALF_LANES    = 4;
    localparam int KEEP_PER_HALF = 2;
    localparam int IDX_W         = 2;
    localparam int ELEM_W        = 8;

    // One nibble of sel per half: [1:0] first-slot index, [3:2] second-slot index.
    localparam int SEL_NIB_W = KEEP_PER_HALF * IDX_W;
    localparam int SEL_LO_LSB = 0;
    localparam int SEL_HI_LSB = SEL_NIB_W;
    localparam int SEL_A_OFS  = 0;
    localparam int SEL_B_OFS  = IDX_W;

    typedef struct packed {
        logic [ELEM_W-1:0] val_a;
        logic [ELEM_W-1:0] val_b;
        logic [IDX_W-1:0]  idx_a;
        logic [IDX_W-1:0]  idx_b;
    } half_sel_t;

    // Unsigned magnitude of an int8; -128 maps to 128 (0x80) with no overflow.
    function automatic logic [ELEM_W-1:0] abs_mag(input logic [ELEM_W-1:0] w);
        return w[ELEM_W-1] ? (~w + ELEM_W'(1)) : w;
    endfunction

    function automatic logic [SEL_NIB_W-1:0] pack_nibble(input half_sel_t h);
        return {h.idx_b, h.idx_a};
    endfunction

endpackage

// File: rtl/sparse_weight_encoder_top2_of_4.sv
// Picks the two largest-magnitude lanes of a 4-lane int8 half (ties to the lower
// index), returns them in index order, and counts the nonzero lanes dropped.
module top2_of_4
    import sparse_pkg::*;
(
    input  logic [HALF_LANES*ELEM_W-1:0] w_i,
    output half_sel_t                    sel_o,
    output logic [1:0]                   pruned_o
);

    logic [ELEM_W-1:0] lane [HALF_LANES];
    logic [ELEM_W-1:0] mag  [HALF_LANES];
    logic [IDX_W-1:0]  best;
    logic [IDX_W-1:0]  sec;

    always_comb begin
        for (int k = 0; k < HALF_LANES; k++) begin
            lane[k] = w_i[k*ELEM_W +: ELEM_W];
            mag[k]  = abs_mag(lane[k]);
        end

        // Strict compares keep the earliest lane on equal magnitudes.
        best = '0;
        for (int k = 1; k < HALF_LANES; k++) begin
            if (mag[k] > mag[best]) best = IDX_W'(k);
        end
        sec = (best == '0) ? IDX_W'(1) : '0;
        for (int k = 0; k < HALF_LANES; k++) begin
            if ((IDX_W'(k) != best) && (mag[k] > mag[sec])) sec = IDX_W'(k);
        end

        sel_o.idx_a = (best < sec) ? best : sec;
        sel_o.idx_b = (best < sec) ? sec : best;
        sel_o.val_a = lane[sel_o.idx_a];
        sel_o.val_b = lane[sel_o.idx_b];

        pruned_o = '0;
        for (int k = 0; k < HALF_LANES; k++) begin
            if ((lane[k] != '0) && (IDX_W'(k) != best) && (IDX_W'(k) != sec))
                pruned_o = pruned_o + 2'd1;
        end
    end

endmodule

// File: rtl/sparse_weight_encoder.sv
// Streaming 2:4 weight compressor: two-stage valid/ready pipeline emitting packed
// values plus selector metadata, with tile-boundary marking and a pruning counter.
module sparse_weight_encoder
    import sparse_pkg::*;
#(
    parameter int TILE_GROUPS = 16,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [GROUP_LANES*ELEM_W-1:0] in_weights,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_values,
    output logic [7:0]                    out_sel,
    output logic                          out_last,
    output logic [CNT_W-1:0]              pruned_cnt,
    input  logic                          cnt_clear
);

    localparam int TILE_W = (TILE_GROUPS > 1) ? $clog2(TILE_GROUPS) : 1;
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILE_GROUPS - 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    half_sel_t         lo_d, hi_d;
    half_sel_t         s1_lo_q, s1_hi_q;
    logic [1:0]        pr_lo, pr_hi;
    logic [2:0]        pruned_grp;
    logic              s1_valid_q, out_valid_q;
    logic              s1_ready, s2_ready, in_fire, out_fire;
    logic [31:0]       out_values_q;
    logic [7:0]        out_sel_q;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [CNT_W-1:0]  pruned_cnt_q, pruned_cnt_d;

    top2_of_4 u_lo (.w_i(in_weights[HALF_LANES*ELEM_W-1:0]),           .sel_o(lo_d), .pruned_o(pr_lo));
    top2_of_4 u_hi (.w_i(in_weights[GROUP_LANES*ELEM_W-1:HALF_LANES*ELEM_W]), .sel_o(hi_d), .pruned_o(pr_hi));

    assign pruned_grp = {1'b0, pr_lo} + {1'b0, pr_hi};
    assign s2_ready   = !out_valid_q || out_ready;
    assign s1_ready   = !s1_valid_q || s2_ready;
    assign in_ready   = s1_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;

    always_comb begin
        pruned_cnt_d = pruned_cnt_q;
        if (cnt_clear)    pruned_cnt_d = '0;
        else if (in_fire) pruned_cnt_d = sat_add(pruned_cnt_q, pruned_grp);

        tile_cnt_d = tile_cnt_q;
        if (out_fire) tile_cnt_d = (tile_cnt_q == TILE_LAST) ? '0 : tile_cnt_q + 1'b1;
    end

    // S1: ranking result per half
    always_ff @(posedge clk) begin
        if (rst)           s1_valid_q <= 1'b0;
        else if (s1_ready) s1_valid_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_lo_q <= lo_d;
            s1_hi_q <= hi_d;
        end
    end

    // S2: packed output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_values_q <= '0;
            out_sel_q    <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_values_q <= {s1_lo_q.val_a, s1_lo_q.val_b, s1_hi_q.val_a, s1_hi_q.val_b};
                out_sel_q    <= {pack_nibble(s1_hi_q), pack_nibble(s1_lo_q)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_q   <= '0;
            pruned_cnt_q <= '0;
        end else begin
            tile_cnt_q   <= tile_cnt_d;
            pruned_cnt_q <= pruned_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_values = out_values_q;
    assign out_sel    = out_sel_q;
    assign out_last   = out_valid_q && (tile_cnt_q == TILE_LAST);
    assign pruned_cnt = pruned_cnt_q;

endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Directed and stall-stress bench for sparse_weight_encoder (TILE_GROUPS=16, CNT_W=16).
module tb_sparse_weight_encoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, cnt_clear;
    logic [63:0] in_weights;
    logic [31:0] out_values;
    logic [7:0]  out_sel;
    logic [15:0] pruned_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int beats = 0;
    int exp_pruned = 0;

    always #5 clk = ~clk;

    sparse_weight_encoder #(.TILE_GROUPS(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_weights(in_weights), .out_valid(out_valid), .out_ready(out_ready),
        .out_values(out_values), .out_sel(out_sel), .out_last(out_last),
        .pruned_cnt(pruned_cnt), .cnt_clear(cnt_clear)
    );

    // Rank-based reference: a lane is kept when fewer than two lanes beat it.
    function automatic void model_group(input logic [63:0] w, output logic [31:0] vals,
                                        output logic [7:0] sel, output int pr);
        pr = 0; vals = '0; sel = '0;
        for (int h = 0; h < 2; h++) begin
            logic [7:0] ln [4];
            int m [4];
            int picked [2];
            int np, rank;
            np = 0;
            for (int k = 0; k < 4; k++) begin
                ln[k] = w[32*h + 8*k +: 8];
                m[k]  = ln[k][7] ? 256 - int'(ln[k]) : int'(ln[k]);
            end
            for (int k = 0; k < 4; k++) begin
                rank = 0;
                for (int j = 0; j < 4; j++)
                    if (j != k && (m[j] > m[k] || (m[j] == m[k] && j < k))) rank++;
                if (rank < 2) begin picked[np] = k; np++; end
                else if (ln[k] != 8'h00) pr++;
            end
            vals[31-16*h -: 8] = ln[picked[0]];
            vals[23-16*h -: 8] = ln[picked[1]];
            sel[4*h +: 2]      = 2'(picked[0]);
            sel[4*h+2 +: 2]    = 2'(picked[1]);
        end
    endfunction

    function automatic logic [63:0] rand_group();
        logic [63:0] g;
        logic [31:0] r;
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            g[8*k +: 8] = (r[1:0] == 2'd0) ? 8'h00 : (r[4:2] == 3'd0) ? 8'h80 : r[15:8];
        end
        return g;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_weights = '0; out_ready = 1'b0; cnt_clear = 1'b0;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_values !== 32'h0) begin n_err++; $display("FAIL reset_out_values got=%h want=00000000", out_values); end
        n_cmp++; if (out_sel !== 8'h0) begin n_err++; $display("FAIL reset_out_sel got=%h want=00", out_sel); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL reset_pruned got=%h want=0000", pruned_cnt); end
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        beats = 0; exp_pruned = 0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] w [40];
        logic [31:0] ev [40];
        logic [7:0]  es [40];
        int pr;
        for (int i = 0; i < 40; i++) begin
            w[i] = rand_group();
            model_group(w[i], ev[i], es[i], pr);
            exp_pruned += pr;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 42; c++) begin
            in_valid = (c < 40);
            in_weights = (c < 40) ? w[c] : 64'h0;
            @(negedge clk);
            if (c < 40) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", c, in_ready); end
            end
            n_cmp++; if (out_valid !== (c >= 2)) begin n_err++; $display("FAIL b2b_out_valid cyc=%0d got=%b want=%b", c, out_valid, (c >= 2)); end
            if (c >= 2 && out_valid === 1'b1) begin
                n_cmp++; if (out_values !== ev[c-2]) begin n_err++; $display("FAIL b2b_values beat=%0d got=%h want=%h", c-2, out_values, ev[c-2]); end
                n_cmp++; if (out_sel !== es[c-2]) begin n_err++; $display("FAIL b2b_sel beat=%0d got=%h want=%h", c-2, out_sel, es[c-2]); end
                n_cmp++; if (out_last !== (c-2 == 15 || c-2 == 31)) begin n_err++; $display("FAIL b2b_last beat=%0d got=%b want=%b", c-2, out_last, (c-2 == 15 || c-2 == 31)); end
                beats++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (pruned_cnt !== 16'(exp_pruned)) begin n_err++; $display("FAIL b2b_pruned got=%0d want=%0d", pruned_cnt, exp_pruned); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1; in_valid = 1'b1; in_weights = 64'h00000000_07FD0005;
        exp_pruned += 1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
        tick(); in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        n_cmp++; if (out_values !== 32'h05070000) begin n_err++; $display("FAIL basic_values got=%h want=05070000", out_values); end
        n_cmp++; if (out_sel !== 8'h4C) begin n_err++; $display("FAIL basic_sel got=%h want=4c", out_sel); end
        n_cmp++; if (out_last !== (beats % 16 == 15)) begin n_err++; $display("FAIL basic_last got=%b want=%b", out_last, (beats % 16 == 15)); end
        n_cmp++; if (pruned_cnt !== 16'(exp_pruned)) begin n_err++; $display("FAIL basic_pruned got=%0d want=%0d", pruned_cnt, exp_pruned); end
        beats++;
        tick();
    endtask

    task automatic test_tie();
        out_ready = 1'b1; in_valid = 1'b1; in_weights = 64'h00000000_80817F80;
        exp_pruned += 2;
        tick(); in_valid = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL tie_valid got=%b want=1", out_valid); end
        n_cmp++; if (out_values !== 32'h80800000) begin n_err++; $display("FAIL tie_values got=%h want=80800000", out_values); end
        n_cmp++; if (out_sel !== 8'h4C) begin n_err++; $display("FAIL tie_sel got=%h want=4c", out_sel); end
        n_cmp++; if (pruned_cnt !== 16'(exp_pruned)) begin n_err++; $display("FAIL tie_pruned got=%0d want=%0d", pruned_cnt, exp_pruned); end
        beats++;
        tick();
    endtask

    task automatic test_random_stall();
        logic [63:0] w [100];
        logic [31:0] ev [100];
        logic [7:0]  es [100];
        logic [31:0] pv;
        logic [7:0]  ps;
        int pr, sent, rcvd;
        bit prev_stall;
        for (int i = 0; i < 100; i++) begin
            w[i] = rand_group();
            model_group(w[i], ev[i], es[i], pr);
            exp_pruned += pr;
        end
        sent = 0; rcvd = 0; prev_stall = 1'b0; pv = '0; ps = '0;
        for (int c = 0; c < 2000 && rcvd < 100; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 100);
            in_weights = (sent < 100) ? w[sent] : 64'h0;
            @(negedge clk);
            n_cmp++; if (in_ready !== !((sent - rcvd) == 2 && !out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", c, in_ready, !((sent - rcvd) == 2 && !out_ready)); end
            if (prev_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || out_values !== pv || out_sel !== ps) begin
                    n_err++; $display("FAIL rnd_hold cyc=%0d got=%b/%h/%h want=1/%h/%h", c, out_valid, out_values, out_sel, pv, ps); end
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (rcvd >= 100) begin n_err++; $display("FAIL rnd_extra_beat got=%0d want=100", rcvd + 1); end
                else if (out_values !== ev[rcvd] || out_sel !== es[rcvd] || out_last !== (beats % 16 == 15)) begin
                    n_err++; $display("FAIL rnd_beat idx=%0d got=%h/%h/%b want=%h/%h/%b", rcvd, out_values, out_sel, out_last, ev[rcvd], es[rcvd], (beats % 16 == 15)); end
            end
            prev_stall = out_valid && !out_ready;
            pv = out_values; ps = out_sel;
            if (out_valid && out_ready) begin rcvd++; beats++; end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (rcvd != 100) begin n_err++; $display("FAIL rnd_count got=%0d want=100", rcvd); end
        n_cmp++; if (pruned_cnt !== 16'(exp_pruned)) begin n_err++; $display("FAIL rnd_pruned got=%0d want=%0d", pruned_cnt, exp_pruned); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ev;
        logic [7:0]  es;
        int pr;
        out_ready = 1'b1; in_valid = 1'b1; in_weights = 64'h0102030405060708;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0; in_valid = 1'b1; in_weights = 64'h11223344_55667788;
        tick();
        in_weights = 64'h99AABBCC_DDEEFF01;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got=%b/%b want=1/0", out_valid, in_ready); end
        rst = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_values !== 32'h0 || out_sel !== 8'h0 || out_last !== 1'b0) begin n_err++; $display("FAIL mid_outputs got=%h/%h/%b want=0/0/0", out_values, out_sel, out_last); end
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL mid_pruned got=%h want=0000", pruned_cnt); end
        rst = 1'b0; out_ready = 1'b1;
        beats = 0; exp_pruned = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_flushed cyc=%0d got=%b/%b want=0/1", c, out_valid, in_ready); end
            tick();
        end
        in_weights = 64'h0000F0F0_03000201;
        model_group(in_weights, ev, es, pr);
        for (int c = 0; c < 18; c++) begin
            in_valid = (c < 16);
            @(negedge clk);
            n_cmp++; if (out_valid !== (c >= 2)) begin n_err++; $display("FAIL mid_tile_valid cyc=%0d got=%b want=%b", c, out_valid, (c >= 2)); end
            if (c >= 2) begin
                n_cmp++; if (out_last !== (c == 17) || out_values !== ev || out_sel !== es) begin
                    n_err++; $display("FAIL mid_tile_beat beat=%0d got=%b/%h/%h want=%b/%h/%h", c-2, out_last, out_values, out_sel, (c == 17), ev, es); end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL sat_clear got=%h want=0000", pruned_cnt); end
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            in_weights = (i == 16383) ? 64'h00000000_01010101 : 64'h01010101_01010101;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (pruned_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload got=%h want=fffe", pruned_cnt); end
        in_valid = 1'b1; in_weights = 64'h01010101_01010101;
        repeat (2) tick();
        in_valid = 1'b0;
        n_cmp++; if (pruned_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got=%h want=ffff", pruned_cnt); end
        in_valid = 1'b1; cnt_clear = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sat_clear_hs_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0; cnt_clear = 1'b0;
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL sat_clear_wins got=%h want=0000", pruned_cnt); end
        tick();
        n_cmp++; if (pruned_cnt !== 16'h0) begin n_err++; $display("FAIL sat_clear_after got=%h want=0000", pruned_cnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_basic();
        test_tie();
        test_random_stall();
        test_reset_midstream();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
